// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm controller.
// Holds the FSM state, blink-field codes, BCD limits and LED patterns.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SET_H,
        SET_M,
        RING,
        SNOOZE
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_HOUR = 2'b01;
    localparam logic [1:0] FIELD_MIN  = 2'b10;

    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    localparam logic [7:0] LED_PAT_A = 8'hF0;
    localparam logic [7:0] LED_PAT_B = 8'h0F;

    function automatic logic [1:0] field_of(input state_t s);
        case (s)
            SET_H:   return FIELD_HOUR;
            SET_M:   return FIELD_MIN;
            default: return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// Two-digit BCD increment that wraps to 00 once the value hits its limit.
// Purely combinational; inputs are assumed to be legal BCD.
module bcd_wrap_inc (
    input  logic [7:0] value,
    input  logic [7:0] limit,
    output logic [7:0] result
);

    logic       carry;
    logic [3:0] units;
    logic [3:0] tens;

    always_comb begin
        carry = (value[3:0] == 4'd9);
        units = carry ? 4'd0 : value[3:0] + 4'd1;
        tens  = carry ? value[7:4] + 4'd1 : value[7:4];
        if (value == limit)
            result = 8'h00;
        else
            result = {tens, units};
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm controller: stores a BCD HH:MM alarm, compares it with the running
// time and sequences ring / snooze / dismiss on the LED bank.
module alarm_scheduler
    import clock_pkg::*;
#(
    parameter logic [7:0] ALARM_H_INIT = 8'h07,
    parameter logic [7:0] ALARM_M_INIT = 8'h00,
    parameter int         RING_SECS    = 60,
    parameter int         SNOOZE_SECS  = 300,
    parameter int         MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       set_btn,
    input  logic       inc_btn,
    input  logic       alarm_en,
    input  logic [7:0] cur_hours,
    input  logic [7:0] cur_minutes,
    input  logic [7:0] cur_seconds,
    output logic [7:0] alarm_hours,
    output logic [7:0] alarm_minutes,
    output logic [1:0] set_field,
    output logic       ringing,
    output logic       snoozing,
    output logic [7:0] led
);

    localparam logic [9:0] RING_LIM   = 10'(RING_SECS);
    localparam logic [9:0] SNOOZE_LIM = 10'(SNOOZE_SECS);
    localparam logic [2:0] SNOOZE_MAX = 3'(MAX_SNOOZE);

    state_t     state, state_n;
    logic [9:0] ring_cnt, ring_cnt_n;
    logic [9:0] snooze_cnt, snooze_cnt_n;
    logic [2:0] snooze_used, snooze_used_n;
    logic [7:0] hours_n, minutes_n, led_n;
    logic [7:0] hours_inc, minutes_inc;
    logic       set_d, inc_d, match_d;
    logic       set_press, inc_press, match_now, trigger;

    bcd_wrap_inc u_hour_inc (
        .value  (alarm_hours),
        .limit  (HOUR_MAX),
        .result (hours_inc)
    );

    bcd_wrap_inc u_min_inc (
        .value  (alarm_minutes),
        .limit  (MIN_MAX),
        .result (minutes_inc)
    );

    // Set wins over inc when both rise in the same cycle.
    assign set_press = set_btn & ~set_d;
    assign inc_press = inc_btn & ~inc_d & ~set_press;

    assign match_now = alarm_en
                     & (cur_hours == alarm_hours)
                     & (cur_minutes == alarm_minutes)
                     & (cur_seconds == 8'h00);
    assign trigger = match_now & ~match_d;

    always_comb begin
        state_n       = state;
        ring_cnt_n    = ring_cnt;
        snooze_cnt_n  = snooze_cnt;
        snooze_used_n = snooze_used;
        hours_n       = alarm_hours;
        minutes_n     = alarm_minutes;
        led_n         = 8'h00;
        case (state)
            IDLE: begin
                if (set_press) begin
                    state_n = SET_H;
                end else if (trigger) begin
                    state_n       = RING;
                    ring_cnt_n    = 10'd0;
                    snooze_used_n = 3'd0;
                    led_n         = LED_PAT_A;
                end
            end
            SET_H: begin
                if (set_press)
                    state_n = SET_M;
                else if (inc_press)
                    hours_n = hours_inc;
            end
            SET_M: begin
                if (set_press)
                    state_n = IDLE;
                else if (inc_press)
                    minutes_n = minutes_inc;
            end
            RING: begin
                led_n = led;
                if (!alarm_en || set_press) begin
                    state_n = IDLE;
                    led_n   = 8'h00;
                end else if (inc_press && snooze_used < SNOOZE_MAX) begin
                    state_n       = SNOOZE;
                    snooze_cnt_n  = SNOOZE_LIM;
                    snooze_used_n = snooze_used + 3'd1;
                    led_n         = 8'h00;
                end else if (tick_1hz) begin
                    ring_cnt_n = ring_cnt + 10'd1;
                    led_n      = (led == LED_PAT_A) ? LED_PAT_B : LED_PAT_A;
                    if (ring_cnt + 10'd1 == RING_LIM) begin
                        state_n = IDLE;
                        led_n   = 8'h00;
                    end
                end
            end
            SNOOZE: begin
                if (!alarm_en || set_press) begin
                    state_n = IDLE;
                end else if (tick_1hz) begin
                    snooze_cnt_n = snooze_cnt - 10'd1;
                    if (snooze_cnt == 10'd1) begin
                        state_n    = RING;
                        ring_cnt_n = 10'd0;
                        led_n      = LED_PAT_A;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ring_cnt      <= 10'd0;
            snooze_cnt    <= 10'd0;
            snooze_used   <= 3'd0;
            alarm_hours   <= ALARM_H_INIT;
            alarm_minutes <= ALARM_M_INIT;
            set_field     <= FIELD_NONE;
            ringing       <= 1'b0;
            snoozing      <= 1'b0;
            led           <= 8'h00;
            set_d         <= 1'b1;
            inc_d         <= 1'b1;
            match_d       <= 1'b0;
        end else begin
            state         <= state_n;
            ring_cnt      <= ring_cnt_n;
            snooze_cnt    <= snooze_cnt_n;
            snooze_used   <= snooze_used_n;
            alarm_hours   <= hours_n;
            alarm_minutes <= minutes_n;
            set_field     <= field_of(state_n);
            ringing       <= (state_n == RING);
            snoozing      <= (state_n == SNOOZE);
            led           <= led_n;
            set_d         <= set_btn;
            inc_d         <= inc_btn;
            match_d       <= match_now;
        end
    end

endmodule
